// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard bus: the register numbers, write enables and hazard
// controls exchanged between the 5-stage pipeline datapath and hazard_ctrl.
// The master is the pipeline; the slave is the hazard controller.
interface hazard_ctrl_if;
    // ID stage sources
    logic [4:0] rsD;
    logic [4:0] rtD;
    // ID/EX register sources
    logic [4:0] rsE;
    logic [4:0] rtE;
    // Destination registers and write enables per stage
    logic [4:0] writeRegE;
    logic [4:0] writeRegM;
    logic [4:0] writeRegW;
    logic       regWriteE;
    logic       regWriteM;
    logic       regWriteW;
    // EX instruction attributes and ID branch resolution
    logic       memToRegE;
    logic       branchTakenD;
    logic       multiStartE;
    // Hazard controls back to the pipeline
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       flushD;
    logic       flushE;
    logic [1:0] forwardAE;
    logic [1:0] forwardBE;
    logic       busy;

    modport master (
        output rsD, rtD, rsE, rtE,
        output writeRegE, writeRegM, writeRegW,
        output regWriteE, regWriteM, regWriteW,
        output memToRegE, branchTakenD, multiStartE,
        input  stallF, stallD, stallE, flushD, flushE,
        input  forwardAE, forwardBE, busy
    );

    modport slave (
        input  rsD, rtD, rsE, rtE,
        input  writeRegE, writeRegM, writeRegW,
        input  regWriteE, regWriteM, regWriteW,
        input  memToRegE, branchTakenD, multiStartE,
        output stallF, stallD, stallE, flushD, flushE,
        output forwardAE, forwardBE, busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / forward control for a 5-stage pipeline with
// a multi-cycle ALU op that occupies EX for MULTI_LAT cycles.
//
// Build option: define HAZARD_FWD_EN to enable EX operand forwarding from
// MEM/WB. Without it, any dependency on an in-flight EX/MEM writer stalls
// the instruction in ID until the value reaches the register file.
//
// Reset is synchronous, active-low. While rst is low every output is held
// at 0 combinationally, so the pipeline sees no stalls during reset.
//
// State | meaning
// ------+-----------------------------------------------------------
// RUN   | normal issue; a multiStartE here starts a multi-cycle op
// MULTI | multi-cycle op still occupying EX; cnt counts remaining cycles
module hazard_ctrl #(
    parameter int MULTI_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_t;

    // The first EX cycle is covered by the combinational multiStart term,
    // so the counter only has to cover the remaining MULTI_LAT-2 cycles.
    localparam logic       HAS_MULTI = (MULTI_LAT > 2);
    localparam logic [4:0] CNT_LOAD  = 5'(MULTI_LAT - 2);

    state_t     state_q;
    state_t     state_d;
    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    logic       multi_start;
    logic       mstall;
    logic       lwstall;
    logic       rawstall;
    logic       stall_front;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // State register and cycle counter; reset aborts any op in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; multiStartE is only honoured while in RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        multi_start = (state_q == RUN) && hz.multiStartE;
        case (state_q)
            RUN: begin
                if (multi_start && HAS_MULTI) begin
                    state_d = MULTI;
                    cnt_d   = CNT_LOAD;
                end
            end
            MULTI: begin
                if (cnt_q == 5'd1) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Load-use hazard: a load in EX feeding the instruction in ID.
    always_comb begin
        lwstall = hz.memToRegE && hz.regWriteE && (hz.writeRegE != 5'd0) &&
                  ((hz.writeRegE == hz.rsD) || (hz.writeRegE == hz.rtD));
    end

`ifdef HAZARD_FWD_EN
    // Operand forwarding for EX; the younger MEM result wins over WB.
    always_comb begin
        fwd_a    = 2'b00;
        fwd_b    = 2'b00;
        rawstall = 1'b0;
        if (hz.regWriteM && (hz.writeRegM != 5'd0) && (hz.writeRegM == hz.rsE))
            fwd_a = 2'b10;
        else if (hz.regWriteW && (hz.writeRegW != 5'd0) && (hz.writeRegW == hz.rsE))
            fwd_a = 2'b01;
        if (hz.regWriteM && (hz.writeRegM != 5'd0) && (hz.writeRegM == hz.rtE))
            fwd_b = 2'b10;
        else if (hz.regWriteW && (hz.writeRegW != 5'd0) && (hz.writeRegW == hz.rtE))
            fwd_b = 2'b01;
    end
`else
    // No forwarding paths: hold ID until EX and MEM writers have drained.
    // WB writers are fine because the register file writes in the first
    // half-cycle and ID reads in the second.
    always_comb begin
        fwd_a    = 2'b00;
        fwd_b    = 2'b00;
        rawstall = (hz.regWriteE && (hz.writeRegE != 5'd0) &&
                    ((hz.writeRegE == hz.rsD) || (hz.writeRegE == hz.rtD))) ||
                   (hz.regWriteM && (hz.writeRegM != 5'd0) &&
                    ((hz.writeRegM == hz.rsD) || (hz.writeRegM == hz.rtD)));
    end

    // Operand sources only used by the forwarding network.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{hz.rsE, hz.rtE, hz.writeRegW, hz.regWriteW};
`endif

    // Output decode, forced to 0 while reset is asserted. A multi-cycle op
    // in EX is never flushed, and a branch held in ID by a stall is not
    // allowed to redirect fetch until the stall releases.
    always_comb begin
        mstall      = multi_start || (state_q == MULTI);
        stall_front = mstall || lwstall || rawstall;

        hz.stallF    = 1'b0;
        hz.stallD    = 1'b0;
        hz.stallE    = 1'b0;
        hz.flushD    = 1'b0;
        hz.flushE    = 1'b0;
        hz.forwardAE = 2'b00;
        hz.forwardBE = 2'b00;
        hz.busy      = 1'b0;
        if (rst) begin
            hz.stallF    = stall_front;
            hz.stallD    = stall_front;
            hz.stallE    = mstall;
            hz.flushE    = (lwstall || rawstall) && !mstall;
            hz.flushD    = hz.branchTakenD && !stall_front;
            hz.forwardAE = fwd_a;
            hz.forwardBE = fwd_b;
            hz.busy      = (state_q == MULTI);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MULTI_LAT = 4). Inputs change 1 ns after
// each rising edge; outputs are sampled on the falling edge.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    hazard_ctrl_if hz_bus ();

    hazard_ctrl #(.MULTI_LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare all single-bit controls in one go.
    task automatic chk_ctl(input string tag, input logic sf, input logic sd, input logic se,
                           input logic fd, input logic fe, input logic bz);
        chk({tag, "_stallF"}, 32'(hz_bus.stallF), 32'(sf));
        chk({tag, "_stallD"}, 32'(hz_bus.stallD), 32'(sd));
        chk({tag, "_stallE"}, 32'(hz_bus.stallE), 32'(se));
        chk({tag, "_flushD"}, 32'(hz_bus.flushD), 32'(fd));
        chk({tag, "_flushE"}, 32'(hz_bus.flushE), 32'(fe));
        chk({tag, "_busy"},   32'(hz_bus.busy),   32'(bz));
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        chk({tag, "_fwdA"}, 32'(hz_bus.forwardAE), 32'(a));
        chk({tag, "_fwdB"}, 32'(hz_bus.forwardBE), 32'(b));
    endtask

    task automatic idle();
        hz_bus.rsD = 5'd0;  hz_bus.rtD = 5'd0;
        hz_bus.rsE = 5'd0;  hz_bus.rtE = 5'd0;
        hz_bus.writeRegE = 5'd0; hz_bus.writeRegM = 5'd0; hz_bus.writeRegW = 5'd0;
        hz_bus.regWriteE = 1'b0; hz_bus.regWriteM = 1'b0; hz_bus.regWriteW = 1'b0;
        hz_bus.memToRegE = 1'b0; hz_bus.branchTakenD = 1'b0; hz_bus.multiStartE = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        idle();

        // Reset: outputs forced low even with hazards and a multi start present.
        step();
        hz_bus.memToRegE = 1'b1; hz_bus.regWriteE = 1'b1; hz_bus.writeRegE = 5'd5;
        hz_bus.rsD = 5'd5; hz_bus.branchTakenD = 1'b1; hz_bus.multiStartE = 1'b1;
        hz_bus.regWriteM = 1'b1; hz_bus.writeRegM = 5'd7; hz_bus.rsE = 5'd7;
        sample(); chk_ctl("rst_hold", 0, 0, 0, 0, 0, 0); chk_fwd("rst_hold", 2'b00, 2'b00);
        step(); idle();
        step();
        rst = 1'b1;
        sample(); chk_ctl("post_rst", 0, 0, 0, 0, 0, 0); chk_fwd("post_rst", 2'b00, 2'b00);

        // Load-use on rs.
        step(); idle();
        hz_bus.memToRegE = 1'b1; hz_bus.regWriteE = 1'b1; hz_bus.writeRegE = 5'd5; hz_bus.rsD = 5'd5;
        sample(); chk_ctl("lw_rs", 1, 1, 0, 0, 1, 0);
        step(); idle();
        sample(); chk_ctl("lw_clear", 0, 0, 0, 0, 0, 0);

        // Load into r0 never stalls.
        step(); idle();
        hz_bus.memToRegE = 1'b1; hz_bus.regWriteE = 1'b1; hz_bus.writeRegE = 5'd0;
        sample(); chk_ctl("lw_r0", 0, 0, 0, 0, 0, 0);

        // Branch with no stall flushes IF/ID.
        step(); idle(); hz_bus.branchTakenD = 1'b1;
        sample(); chk_ctl("br_free", 0, 0, 0, 1, 0, 0);

        // Load-use stalls a branch: no flushD that cycle.
        step(); idle();
        hz_bus.memToRegE = 1'b1; hz_bus.regWriteE = 1'b1; hz_bus.writeRegE = 5'd9;
        hz_bus.rtD = 5'd9; hz_bus.branchTakenD = 1'b1;
        sample(); chk_ctl("lw_br", 1, 1, 0, 0, 1, 0);

        // WB-stage writer never stalls ID.
        step(); idle();
        hz_bus.regWriteW = 1'b1; hz_bus.writeRegW = 5'd4; hz_bus.rsD = 5'd4;
        sample(); chk_ctl("wb_nostall", 0, 0, 0, 0, 0, 0);

`ifdef HAZARD_FWD_EN
        step(); idle();
        hz_bus.regWriteM = 1'b1; hz_bus.writeRegM = 5'd7;
        hz_bus.regWriteW = 1'b1; hz_bus.writeRegW = 5'd7; hz_bus.rsE = 5'd7; hz_bus.rtE = 5'd7;
        sample(); chk_fwd("fwd_mem", 2'b10, 2'b10);
        hz_bus.regWriteM = 1'b0;
        sample(); chk_fwd("fwd_wb", 2'b01, 2'b01);
        hz_bus.rsE = 5'd0;
        sample(); chk_fwd("fwd_r0", 2'b00, 2'b01);
        step(); idle();
        hz_bus.regWriteM = 1'b1; hz_bus.writeRegM = 5'd3; hz_bus.rtD = 5'd3;
        sample(); chk_ctl("fwd_noraw", 0, 0, 0, 0, 0, 0);
`else
        // MEM writer dependency stalls without forwarding.
        step(); idle();
        hz_bus.regWriteM = 1'b1; hz_bus.writeRegM = 5'd3; hz_bus.rtD = 5'd3;
        hz_bus.rsE = 5'd3; hz_bus.rtE = 5'd3;
        sample(); chk_ctl("raw_mem", 1, 1, 0, 0, 1, 0); chk_fwd("raw_mem", 2'b00, 2'b00);
        // Non-load EX writer dependency.
        step(); idle();
        hz_bus.regWriteE = 1'b1; hz_bus.writeRegE = 5'd12; hz_bus.rsD = 5'd12;
        sample(); chk_ctl("raw_ex", 1, 1, 0, 0, 1, 0);
        // MEM writer to r0 is ignored.
        step(); idle();
        hz_bus.regWriteM = 1'b1; hz_bus.writeRegM = 5'd0;
        sample(); chk_ctl("raw_r0", 0, 0, 0, 0, 0, 0);
`endif

        // Multi-cycle op, start at N, branch taken from N+1 onward.
        step(); idle(); hz_bus.multiStartE = 1'b1;
        sample(); chk_ctl("multi_n", 1, 1, 1, 0, 0, 0);
        step(); idle(); hz_bus.branchTakenD = 1'b1; hz_bus.multiStartE = 1'b1;
        sample(); chk_ctl("multi_n1", 1, 1, 1, 0, 0, 1);
        step(); hz_bus.multiStartE = 1'b0;
        sample(); chk_ctl("multi_n2", 1, 1, 1, 0, 0, 1);
        step();
        sample(); chk_ctl("multi_n3", 0, 0, 0, 1, 0, 0);

        // Hazard alongside a multi start: stall everything, never flush EX.
        step(); idle();
        hz_bus.multiStartE = 1'b1;
        hz_bus.memToRegE = 1'b1; hz_bus.regWriteE = 1'b1; hz_bus.writeRegE = 5'd6; hz_bus.rsD = 5'd6;
        sample(); chk_ctl("multi_lw", 1, 1, 1, 0, 0, 0);
        step(); idle();
        sample(); chk_ctl("multi_lw1", 1, 1, 1, 0, 0, 1);
        step();
        sample(); chk_ctl("multi_lw2", 1, 1, 1, 0, 0, 1);
        step();
        sample(); chk_ctl("multi_lw3", 0, 0, 0, 0, 0, 0);

        // Reset mid-MULTI aborts the op.
        step(); idle(); hz_bus.multiStartE = 1'b1;
        sample(); chk_ctl("abort_n", 1, 1, 1, 0, 0, 0);
        step(); idle(); rst = 1'b0;
        sample(); chk_ctl("abort_rst", 0, 0, 0, 0, 0, 0);
        step(); rst = 1'b1;
        sample(); chk_ctl("abort_rel", 0, 0, 0, 0, 0, 0);
        step();
        sample(); chk_ctl("abort_rel1", 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULTI_LAT, default 4: cycles a multi-cycle ALU op occupies EX; legal range 2..32.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  reset; synchronous, active-low (0 = reset).
REQ-004 rsD, rtD  in  5 each  source register numbers of the instruction in ID.
REQ-005 rsE, rtE  in  5 each  source register numbers held in the ID/EX register.
REQ-006 writeRegE, writeRegM, writeRegW  in  5 each  destination register in EX/MEM/WB.
REQ-007 regWriteE, regWriteM, regWriteW  in  1 each  register-file write enable per stage.
REQ-008 memToRegE  in  1  EX instruction is a load.
REQ-009 branchTakenD  in  1  branch/jump resolved taken in ID.
REQ-010 multiStartE  in  1  EX holds a multi-cycle ALU op (first EX cycle).
REQ-011 stallF, stallD, stallE  out  1 each  hold PC, IF/ID, ID/EX.
REQ-012 flushD, flushE  out  1 each  clear IF/ID, ID/EX (flushE drives ID/EX flushE).
REQ-013 forwardAE, forwardBE  out  2 each  EX operand source: 00 regfile, 01 WB, 10 MEM.
REQ-014 busy  out  1  high while state = MULTI.

Function
REQ-015 FSM states RUN, MULTI; 5-bit down-counter cnt.
REQ-016 multiStart = (state==RUN) && multiStartE.
REQ-017 RUN->MULTI when multiStart && MULTI_LAT>2; cnt loaded MULTI_LAT-2; with MULTI_LAT==2, stays RUN.
REQ-018 MULTI: cnt==1 -> RUN; otherwise cnt decrements; multiStartE ignored in MULTI.
REQ-019 mstall = multiStart || (state==MULTI); total mstall cycles per op = MULTI_LAT-1.
REQ-020 lwstall = memToRegE && regWriteE && writeRegE!=0 && (writeRegE==rsD || writeRegE==rtD); combinational, same cycle.
REQ-021 stallE = mstall; stallF = stallD = mstall || lwstall || rawstall.
REQ-022 flushE = (lwstall || rawstall) && !mstall; a multi-cycle op in EX is never flushed.
REQ-023 flushD = branchTakenD && !stallD; a stalled branch is not taken until released.
REQ-024 Register 0 never causes a stall or forward.
REQ-025 Register file writes in the first half-cycle; WB-stage writers never stall ID.

Reset
REQ-026 rst==0 at posedge: state=RUN, cnt=0, regardless of current state (mid-MULTI abort).
REQ-027 While rst==0, all outputs are 0 (stalls, flushes, forwards, busy).
REQ-028 First cycle after reset release: RUN, no stall unless inputs demand it combinationally.

Configuration
REQ-029 Macro HAZARD_FWD_EN defined: forwardAE = 10 if regWriteM && writeRegM!=0 && writeRegM==rsE, else 01 if same test on W, else 00; forwardBE likewise on rtE; MEM wins over WB; rawstall = 0.
REQ-030 HAZARD_FWD_EN undefined: forwardAE = forwardBE = 00; rawstall = (regWriteE && writeRegE!=0 && writeRegE in {rsD,rtD}) || (regWriteM && writeRegM!=0 && writeRegM in {rsD,rtD}).

Verification
REQ-031 Load-use: memToRegE=1, regWriteE=1, writeRegE=5, rsD=5 -> stallF=stallD=flushE=1 for 1 cycle, stallE=0.
REQ-032 Multi-op: MULTI_LAT=4, multiStartE pulse at cycle N -> stallF/D/E high N..N+2, busy N+1..N+2, all low N+3.
REQ-033 Branch during multi: branchTakenD=1 at N+1 of REQ-032 -> flushD=0 until N+3, then flushD=1; flushE never asserted.
REQ-034 Forwarding (HAZARD_FWD_EN): writeRegM=writeRegW=7, both regWrite=1, rsE=7 -> forwardAE=10; regWriteM=0 -> 01; rsE=0 -> 00.
REQ-035 No-forward build: regWriteM=1, writeRegM=3, rtD=3 -> stallF=stallD=flushE=1, forwards 00.
REQ-036 Reset mid-MULTI: rst=0 at N+1 of REQ-032 -> all outputs 0 that cycle; after release, state RUN, busy=0.
